// File: rtl/if_id_fetch_stage_if.sv
// Bundles the fetch stage's instruction-memory bus and ID-stage control signals.
// master is the fetch stage itself; slave is the surrounding core (ROM, decoder, hazard unit).
interface if_id_fetch_stage_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] InstrAddr;
    logic [DATA_WIDTH-1:0] InstrData;
    logic                  Stall;
    logic                  Jump;
    logic                  JumpReg;
    logic                  BranchEQ;
    logic                  BranchNE;
    logic                  RegEqual;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] PC;
    logic [DATA_WIDTH-1:0] Instruction_ID;
    logic [DATA_WIDTH-1:0] PC4_ID;
    logic [5:0]            OP;
    logic                  Valid_ID;
    logic                  Redirect;

    modport master (
        output InstrAddr, PC, Instruction_ID, PC4_ID, OP, Valid_ID, Redirect,
        input  InstrData, Stall, Jump, JumpReg, BranchEQ, BranchNE, RegEqual, ReadData1
    );

    modport slave (
        input  InstrAddr, PC, Instruction_ID, PC4_ID, OP, Valid_ID, Redirect,
        output InstrData, Stall, Jump, JumpReg, BranchEQ, BranchNE, RegEqual, ReadData1
    );
endinterface

// File: rtl/if_id_fetch_stage.sv
// MIPS fetch stage with IF/ID register; jumps and branches resolve in ID with one bubble
// and no delay slot.
module if_id_fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h0040_0000,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic                clk,
    input logic                reset,
    if_id_fetch_stage_if.master bus
);

    logic [DATA_WIDTH-1:0] pcQ, pcD;
    logic [DATA_WIDTH-1:0] instrQ, instrD;
    logic [DATA_WIDTH-1:0] pc4Q, pc4D;
    logic                  validQ, validD;

    logic [DATA_WIDTH-1:0] pcPlus4;
    logic [DATA_WIDTH-1:0] branchOffset;
    logic [DATA_WIDTH-1:0] target;
    logic                  taken;

    assign pcPlus4      = pcQ + DATA_WIDTH'(4);
    assign branchOffset = {{14{instrQ[15]}}, instrQ[15:0], 2'b00};

    // Decoder outputs only matter while ID holds a real instruction.
    assign taken = validQ & (bus.Jump | bus.JumpReg |
                             (bus.BranchEQ & bus.RegEqual) |
                             (bus.BranchNE & ~bus.RegEqual));

    always_comb begin
        target = pc4Q + branchOffset;
        if (bus.JumpReg) begin
            target = {bus.ReadData1[DATA_WIDTH-1:2], 2'b00};
        end else if (bus.Jump) begin
            target = {pc4Q[DATA_WIDTH-1:28], instrQ[25:0], 2'b00};
        end
    end

    always_comb begin
        pcD    = pcQ;
        instrD = instrQ;
        pc4D   = pc4Q;
        validD = validQ;
        if (bus.Stall) begin
            // Hold everything; a pending branch re-evaluates with fresh RegEqual.
        end else if (taken) begin
            pcD    = target;
            instrD = '0;
            pc4D   = '0;
            validD = 1'b0;
        end else begin
            pcD    = pcPlus4;
            instrD = bus.InstrData;
            pc4D   = pcPlus4;
            validD = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcQ    <= PC_RESET;
            instrQ <= '0;
            pc4Q   <= '0;
            validQ <= 1'b0;
        end else begin
            pcQ    <= pcD;
            instrQ <= instrD;
            pc4Q   <= pc4D;
            validQ <= validD;
        end
    end

    assign bus.InstrAddr      = pcQ;
    assign bus.PC             = pcQ;
    assign bus.Instruction_ID = instrQ;
    assign bus.PC4_ID         = pc4Q;
    assign bus.OP             = instrQ[31:26];
    assign bus.Valid_ID       = validQ;
    assign bus.Redirect       = taken & ~bus.Stall;

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
Fetch stage plus IF/ID pipeline register that feeds the opcode decoder (OP[5:0]) of the pipelined MIPS core.
- Holds the PC and drives the instruction-memory address.
- Captures the fetched word and PC+4 into the IF/ID register.
- Resolves jumps and branches in ID from decoder outputs; a taken redirect squashes the wrong-path fetch (no delay slot).

Parameters:
PC_RESET, 32'h0040_0000, PC value loaded on reset
DATA_WIDTH, 32, instruction/PC width (only 32 supported)

Ports:
clk  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
InstrAddr  out  32  instruction-memory address, equals PC combinationally
InstrData  in  32  instruction word for InstrAddr, valid same cycle (combinational ROM)
Stall  in  1  hazard-unit hold: freeze PC and IF/ID
Jump  in  1  decoder output for the ID instruction (j/jal)
JumpReg  in  1  ID instruction is jr
BranchEQ  in  1  decoder output, beq in ID
BranchNE  in  1  decoder output, bne in ID
RegEqual  in  1  ID-stage comparator result, rs==rt
ReadData1  in  32  rs value in ID (jr target)
PC  out  32  current fetch PC
Instruction_ID  out  32  IF/ID instruction
PC4_ID  out  32  IF/ID PC+4
OP  out  6  Instruction_ID[31:26], to decoder
Valid_ID  out  1  IF/ID holds a real instruction
Redirect  out  1  combinational, taken control transfer this cycle

Behaviour:
Reset
- reset=1 at an edge: PC<=PC_RESET, Instruction_ID<=0, PC4_ID<=0, Valid_ID<=0.
- Reset overrides every other input, including mid-stall and mid-redirect.

Redirect decision (combinational)
- Taken = Valid_ID & (Jump | JumpReg | (BranchEQ & RegEqual) | (BranchNE & ~RegEqual)).
- Redirect = Taken & ~Stall.
- Decoder inputs are ignored when Valid_ID=0.

Target selection (priority JumpReg > Jump > branch)
- jr: {ReadData1[31:2],2'b00}; low two bits are forced to zero, no exception.
- j/jal: {PC4_ID[31:28], Instruction_ID[25:0], 2'b00}.
- beq/bne: PC4_ID + ({{14{Instruction_ID[15]}}, Instruction_ID[15:0], 2'b00}), modulo 2^32.

Edge update, priority reset > Stall > Redirect > sequential
- Stall=1: PC, Instruction_ID, PC4_ID and Valid_ID are all held. A pending branch is re-evaluated next cycle with fresh RegEqual.
- Redirect=1: PC<=target; Instruction_ID<=0, PC4_ID<=0, Valid_ID<=0. The wrong-path word is squashed; 0 decodes as an R-type NOP.
- Otherwise: PC<=PC+4 (32-bit wrap, 0xFFFF_FFFC -> 0); Instruction_ID<=InstrData; PC4_ID<=PC+4; Valid_ID<=1.

Latency
- An instruction appears on OP one cycle after its address is on InstrAddr.
- Taken transfer costs one bubble: the target address is presented the cycle after the redirect.
- No state exists besides PC and the IF/ID register; outputs other than Redirect and InstrAddr are registered.
- Consecutive redirects are impossible: the bubble following a redirect has Valid_ID=0.

Test Plan:
- Reset: assert reset 2 cycles with Stall=1 -> PC=0x00400000, Valid_ID=0, OP=0. Release, ROM word 0x20080005 at 0x00400000 -> next cycle Instruction_ID=0x20080005, OP=0x08, PC4_ID=0x00400004, PC=0x00400004.
- Sequential and wrap: force PC to 0xFFFFFFFC via jr -> following cycle PC=0x00000000, PC4_ID=0x00000000.
- beq taken: ID holds 0x1109FFFF at 0x00400010, BranchEQ=1, RegEqual=1 -> Redirect=1; next PC=0x00400010; Valid_ID=0 for one cycle. Same with RegEqual=0 -> no redirect, PC advances by 4.
- bne and j: bne with RegEqual=0 and offset +3 at 0x00400020 -> PC=0x00400030. j 0x0100008 at PC4_ID=0x00400004 -> PC=0x00400020.
- Stall and branch: BranchEQ=1, RegEqual=0, Stall=1 for 2 cycles -> PC and IF/ID held, Redirect=0. Then Stall=0, RegEqual=1 -> redirect taken.
- jr misaligned and reset mid-redirect: jr with ReadData1=0x00400033 -> PC=0x00400030. Assert reset in the same cycle as a taken branch -> PC=PC_RESET, Valid_ID=0.
